regfile_writeback: RTL

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 91 +++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// Writeback arbiter and register scoreboard.
// Merges ALU and load results into a single register-file write port.
// It also tracks which registers still have a write outstanding.
//
// Handshake: the ALU has no ready signal and always wins the port.
// The load unit uses valid/ready. A load transfers only on a cycle where
// lsu_valid && lsu_ready. While lsu_valid=1 and lsu_ready=0 the source
// must hold lsu_rd/lsu_data steady; nothing is captured for it here.
module regfile_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  // Pending bits for x1..x31. x0 is hard-wired to "never pending".
  logic [31:1] pending_q;
  logic [31:0] pending;
  assign pending = {pending_q, 1'b0};

  logic        lsu_take;
  logic        acc_valid;
  logic [4:0]  acc_rd;
  logic [31:0] acc_data;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;

  // Source selection: the ALU has fixed priority and the load waits.
  always_comb begin
    lsu_ready = rst & ~alu_valid;
    lsu_take  = lsu_valid & lsu_ready;
    acc_valid = alu_valid | lsu_take;
    acc_rd    = alu_valid ? alu_rd   : lsu_rd;
    acc_data  = alu_valid ? alu_data : lsu_data;
  end

  // Scoreboard update masks. A set is applied after a clear, so the set wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && (issue_rd != 5'd0)) set_mask[issue_rd] = 1'b1;
    if (acc_valid && (acc_rd != 5'd0))     clr_mask[acc_rd]   = 1'b1;
  end

  // Busy lookup. A result accepted this cycle for the queried register
  // already counts as resolved.
  always_comb begin
    rs1_busy = (rs1 != 5'd0) && pending[rs1] && !(acc_valid && (acc_rd == rs1));
    rs2_busy = (rs2 != 5'd0) && pending[rs2] && !(acc_valid && (acc_rd == rs2));
  end

  // Pending register. Clears are applied first and sets second.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_mask[31:1]) | set_mask[31:1];
    end
  end

  // Registered write port. Address and data hold their values when no
  // source is selected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_we   <= 1'b0;
      wb_rd   <= 5'd0;
      wb_data <= 32'd0;
    end else begin
      wb_we <= acc_valid && (acc_rd != 5'd0);
      if (acc_valid) begin
        wb_rd   <= acc_rd;
        wb_data <= acc_data;
      end
    end
  end

endmodule
